// File: rtl/tero_scan_ctrl_if.sv
// Handshake and datapath bundle between the PUF top level, the scan sequencer
// and the TERO mux/counter datapath.
interface tero_scan_ctrl_if #(
   parameter int NUM_LOOPS      = 32,
   parameter int CHALLENGE_BITS = 4,
   parameter int CNT_WIDTH      = 16
);
   localparam int SEL_W = $clog2(NUM_LOOPS);

   logic                      start;
   logic [CHALLENGE_BITS-1:0] challenge_in;
   logic [CNT_WIDTH-1:0]      cnt_in;
   logic [SEL_W-1:0]          tero_sel;
   logic                      tero_clr;
   logic                      tero_en;
   logic                      busy;
   logic                      done;
   logic [NUM_LOOPS/2-1:0]    response;

   modport master (
      output start, challenge_in, cnt_in,
      input  tero_sel, tero_clr, tero_en, busy, done, response
   );

   modport slave (
      input  start, challenge_in, cnt_in,
      output tero_sel, tero_clr, tero_en, busy, done, response
   );
endinterface

// File: rtl/tero_scan_ctrl.sv
// TERO PUF scan sequencer: walks every loop in challenge-rotated order through
// clear / measure / hold / sample phases and builds the pairwise response word.
module tero_scan_ctrl #(
   parameter int NUM_LOOPS      = 32,
   parameter int CHALLENGE_BITS = 4,
   parameter int CNT_WIDTH      = 16,
   parameter int WINDOW_CYCLES  = 1024,
   parameter int SETTLE_CYCLES  = 4
) (
   input logic              clk,
   input logic              reset,
   tero_scan_ctrl_if.slave  bus
);
   localparam int SEL_W = $clog2(NUM_LOOPS);
   localparam int HALF  = NUM_LOOPS / 2;
   localparam int MAXC  = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
   localparam int TW    = $clog2(MAXC + 1);
   localparam logic [SEL_W-1:0] LAST_STEP = SEL_W'(NUM_LOOPS - 1);
   localparam logic [TW-1:0]    SETTLE_LD = TW'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0]    WINDOW_LD = TW'(WINDOW_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, CLEAR, MEASURE, HOLD, SAMPLE, DONE} state_t;

   state_t                    state_reg, state_next;
   logic [SEL_W-1:0]          step_reg, step_next;
   logic [CHALLENGE_BITS-1:0] chal_reg, chal_next;
   logic [TW-1:0]             timer_reg, timer_next;
   logic [CNT_WIDTH-1:0]      prev_reg, prev_next;
   logic [HALF-1:0]           shadow_reg, shadow_next;
   logic [SEL_W-1:0]          tero_sel_reg;
   logic                      tero_clr_reg;
   logic                      tero_en_reg;
   logic                      busy_reg;
   logic                      done_reg;
   logic [HALF-1:0]           response_reg;
   logic [HALF-1:0]           pair_hit;
   logic                      pair_gt;

   // One-hot select of the response bit owned by the current loop pair.
   for (genvar gi = 0; gi < HALF; gi++) begin : g_pair
      assign pair_hit[gi] = ((step_reg >> 1) == SEL_W'(gi));
   end

   assign pair_gt = (prev_reg > bus.cnt_in);

   always_comb begin
      state_next  = state_reg;
      step_next   = step_reg;
      chal_next   = chal_reg;
      timer_next  = timer_reg;
      prev_next   = prev_reg;
      shadow_next = shadow_reg;
      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               chal_next   = bus.challenge_in;
               step_next   = '0;
               shadow_next = '0;
               timer_next  = SETTLE_LD;
               state_next  = CLEAR;
            end
         end
         CLEAR: begin
            if (timer_reg == '0) begin
               timer_next = WINDOW_LD;
               state_next = MEASURE;
            end else begin
               timer_next = timer_reg - 1'b1;
            end
         end
         MEASURE: begin
            if (timer_reg == '0) begin
               timer_next = SETTLE_LD;
               state_next = HOLD;
            end else begin
               timer_next = timer_reg - 1'b1;
            end
         end
         HOLD: begin
            if (timer_reg == '0) begin
               state_next = SAMPLE;
            end else begin
               timer_next = timer_reg - 1'b1;
            end
         end
         SAMPLE: begin
            if (!step_reg[0]) begin
               prev_next = bus.cnt_in;
            end else begin
               shadow_next = (shadow_reg & ~pair_hit) | (pair_hit & {HALF{pair_gt}});
            end
            if (step_reg == LAST_STEP) begin
               state_next = DONE;
            end else begin
               step_next  = step_reg + 1'b1;
               timer_next = SETTLE_LD;
               state_next = CLEAR;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Outputs are registered from next-state values so they line up with the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         step_reg     <= '0;
         chal_reg     <= '0;
         timer_reg    <= '0;
         prev_reg     <= '0;
         shadow_reg   <= '0;
         tero_sel_reg <= '0;
         tero_clr_reg <= 1'b0;
         tero_en_reg  <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         response_reg <= '0;
      end else begin
         state_reg    <= state_next;
         step_reg     <= step_next;
         chal_reg     <= chal_next;
         timer_reg    <= timer_next;
         prev_reg     <= prev_next;
         shadow_reg   <= shadow_next;
         tero_sel_reg <= (state_next == IDLE) ? '0 : step_next + SEL_W'(chal_next);
         tero_clr_reg <= (state_next == CLEAR);
         tero_en_reg  <= (state_next == MEASURE);
         busy_reg     <= (state_next != IDLE);
         done_reg     <= (state_next == DONE);
         if (state_next == DONE) begin
            response_reg <= shadow_next;
         end
      end
   end

   assign bus.tero_sel = tero_sel_reg;
   assign bus.tero_clr = tero_clr_reg;
   assign bus.tero_en  = tero_en_reg;
   assign bus.busy     = busy_reg;
   assign bus.done     = done_reg;
   assign bus.response = response_reg;
endmodule

// File: tb/tb_tero_scan_ctrl.sv
// Bench for tero_scan_ctrl with a small 4-loop configuration; the response is
// predicted from the loop-pair comparison rule over a count table.
module tb_tero_scan_ctrl;
   localparam int N  = 4;
   localparam int W  = 8;
   localparam int S  = 2;
   localparam int L  = 2 * S + W + 1;
   localparam int LAT = 1 + N * L;

   logic clk = 1'b0;
   logic reset;
   int checks = 0;
   int errors = 0;

   tero_scan_ctrl_if #(.NUM_LOOPS(N), .CHALLENGE_BITS(2), .CNT_WIDTH(16)) bus ();

   tero_scan_ctrl #(
      .NUM_LOOPS(N), .CHALLENGE_BITS(2), .CNT_WIDTH(16),
      .WINDOW_CYCLES(W), .SETTLE_CYCLES(S)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [15:0] cnt_tab [N];
   assign bus.cnt_in = cnt_tab[bus.tero_sel];

   // Cumulative monitor statistics, sampled on the falling edge.
   int done_n = 0, overlap_n = 0, sel_bad_n = 0, en_run = 0;
   int sel_q[$];
   int run_q[$];
   logic clr_prev = 1'b0, en_prev = 1'b0;
   logic [1:0] sel_prev = '0;

   always @(negedge clk) begin
      if (bus.tero_clr && bus.tero_en) overlap_n++;
      if (bus.done) done_n++;
      if (bus.busy && bus.tero_sel != sel_prev && !(bus.tero_clr && !clr_prev)) sel_bad_n++;
      if (bus.tero_clr && !clr_prev) sel_q.push_back(int'(bus.tero_sel));
      if (bus.tero_en) begin
         en_run++;
      end else if (en_prev) begin
         run_q.push_back(en_run);
         en_run = 0;
      end
      clr_prev = bus.tero_clr;
      en_prev  = bus.tero_en;
      sel_prev = bus.tero_sel;
   end

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Loop pair p compares the loops visited at steps 2p and 2p+1.
   function automatic logic [1:0] model(input int chal);
      logic [1:0] r;
      for (int p = 0; p < N / 2; p++) begin
         r[p] = cnt_tab[(2 * p + chal) % N] > cnt_tab[(2 * p + 1 + chal) % N];
      end
      return r;
   endfunction

   task automatic do_scan(input int chal, input bit spam);
      int d0, o0, s0, sq0, rq0, cyc;
      logic [1:0] exp_r;
      d0 = done_n; o0 = overlap_n; s0 = sel_bad_n;
      sq0 = sel_q.size(); rq0 = run_q.size();
      exp_r = model(chal);
      @(posedge clk); #1;
      bus.challenge_in = 2'(chal);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.challenge_in = 2'($urandom);
      cyc = 0;
      while (cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (spam) bus.start = (cyc == LAT) ? 1'b1 : 1'($urandom_range(0, 1));
         if (bus.done) break;
      end
      chk("done_latency", cyc, LAT);
      chk("response", bus.response, exp_r);
      chk("busy_in_done", bus.busy, 1);
      @(negedge clk);
      bus.start = 1'b0;
      chk("busy_after_done", bus.busy, 0);
      chk("done_one_cycle", bus.done, 0);
      repeat (30) @(negedge clk);
      chk("done_pulses", done_n - d0, 1);
      chk("idle_busy", bus.busy, 0);
      chk("response_held", bus.response, exp_r);
      chk("sel_steps", sel_q.size() - sq0, N);
      for (int i = 0; i < N && sq0 + i < sel_q.size(); i++)
         chk("sel_order", sel_q[sq0 + i], (i + chal) % N);
      chk("en_windows", run_q.size() - rq0, N);
      for (int i = 0; i < N && rq0 + i < run_q.size(); i++)
         chk("en_window_len", run_q[rq0 + i], W);
      chk("clr_en_overlap", overlap_n - o0, 0);
      chk("sel_stable", sel_bad_n - s0, 0);
      $display("scan chal=%0d spam=%0d response=%b expected=%b latency=%0d",
               chal, spam, bus.response, exp_r, cyc);
   endtask

   initial begin
      int d0, cyc;
      bus.start = 1'b0;
      bus.challenge_in = '0;
      cnt_tab = '{16'd100, 16'd50, 16'd30, 16'd90};
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_clr", bus.tero_clr, 0);
      chk("rst_en", bus.tero_en, 0);
      chk("rst_sel", bus.tero_sel, 0);
      chk("rst_response", bus.response, 0);

      do_scan(0, 1'b0);
      do_scan(1, 1'b0);
      cnt_tab = '{16'd77, 16'd77, 16'd77, 16'd77};
      do_scan(2, 1'b0);
      cnt_tab = '{16'd100, 16'd50, 16'd30, 16'd90};
      do_scan(3, 1'b1);

      // Reset during the measure window of step 2.
      d0 = done_n;
      @(posedge clk); #1;
      bus.challenge_in = 2'd0;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      cyc = 0;
      repeat (2 * L + S + 4) begin
         @(negedge clk);
         cyc++;
      end
      chk("mid_in_measure", bus.tero_en, 1);
      chk("mid_sel", bus.tero_sel, 2);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_en", bus.tero_en, 0);
      chk("mid_rst_clr", bus.tero_clr, 0);
      chk("mid_rst_response", bus.response, 0);
      chk("mid_rst_done", bus.done, 0);
      reset = 1'b0;
      repeat (LAT + 10) @(negedge clk);
      chk("mid_rst_no_done", done_n - d0, 0);
      chk("mid_rst_idle", bus.busy, 0);
      $display("reset mid-scan after %0d cycles busy=%0d response=%b", cyc, bus.busy, bus.response);
      do_scan(0, 1'b0);

      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < N; i++) cnt_tab[i] = 16'($urandom_range(0, 7));
         do_scan(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
